fetch_enqueuer: RTL and testbench

FETCH_ENQUEUER -- requirements
Module: fetch_enqueuer

---
 rtl/fetch_enqueuer.sv | 212 +++++++++++++++++++++
 tb/tb_fetch_enqueuer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_enqueuer.sv
// fetch_enqueuer
//   Sequential instruction fetch front end. Issues word-aligned requests to
//   an in-order instruction memory and pushes {pc, instr} pairs into a
//   downstream queue. Outstanding requests plus buffered responses never
//   exceed MAX_OUT, so every response that comes back has a skid slot. A
//   flush redirects the fetch stream and silently drains the responses that
//   are still in flight for the old stream.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | just out of reset, moves to RUN on the first clock
//   RUN   | issue requests, capture responses, enqueue skid entries
//   DRAIN | discard drop_cnt stale responses after a flush, no issue
//
// Ports
//   clk, reset          rising-edge clock, asynchronous active-low reset
//   stall               freezes request issue and enqueue (not capture)
//   flush, redirect_pc  discard fetch stream, restart at redirect_pc
//   imem_req/imem_addr  request strobe and word address
//   imem_valid/imem_data in-order response strobe and instruction word
//   halt                downstream queue full
//   enque/enque_data    push strobe and {pc, instr} entry (0 when idle)
//   err                 sticky: response seen with nothing outstanding
module fetch_enqueuer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          MAX_OUT  = 2,
  parameter              TAG      = "Fetch"
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_data,
  input  logic        halt,
  output logic        enque,
  output logic [63:0] enque_data,
  output logic        err
);

  localparam int CNT_W = $clog2(MAX_OUT + 1);
  localparam int PTR_W = $clog2(MAX_OUT);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W:0]   LIMIT    = (CNT_W + 1)'(MAX_OUT);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [CNT_W-1:0] skid_cnt_q, skid_cnt_d;
  logic [PTR_W-1:0] skid_wr_q, skid_wr_d;
  logic [PTR_W-1:0] skid_rd_q, skid_rd_d;
  logic [PTR_W-1:0] tag_wr_q, tag_wr_d;
  logic [PTR_W-1:0] tag_rd_q, tag_rd_d;
  logic             err_q, err_d;

  logic [63:0] skid_mem_q [MAX_OUT];
  logic [63:0] skid_mem_d [MAX_OUT];
  logic [31:0] tag_mem_q  [MAX_OUT];
  logic [31:0] tag_mem_d  [MAX_OUT];

  logic [CNT_W:0] occupancy;
  logic           room;
  logic           issue;
  logic           rsp_ok;
  logic           rsp_bad;
  logic           capture;
  logic           pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_ONE;
  endfunction

  // Issue is gated on in-flight plus buffered entries so a response always
  // finds a free skid slot, even while the downstream queue is halted.
  assign occupancy = {1'b0, out_cnt_q} + {1'b0, skid_cnt_q};
  assign room      = occupancy < LIMIT;
  assign issue     = (state_q == S_RUN) && !stall && !flush && room;
  assign rsp_ok    = imem_valid && (out_cnt_q != '0);
  assign rsp_bad   = imem_valid && (out_cnt_q == '0);
  assign capture   = rsp_ok && (state_q == S_RUN) && !flush;
  assign pop       = (skid_cnt_q != '0) && !halt && !stall && !flush;

  assign imem_req   = issue;
  assign imem_addr  = pc_q;
  assign enque      = pop;
  assign enque_data = pop ? skid_mem_q[skid_rd_q] : 64'd0;
  assign err        = err_q;

  always_comb begin
    out_cnt_d = out_cnt_q;
    if (issue && !rsp_ok) begin
      out_cnt_d = out_cnt_q + CNT_ONE;
    end else if (!issue && rsp_ok) begin
      out_cnt_d = out_cnt_q - CNT_ONE;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    drop_cnt_d = drop_cnt_q;
    skid_cnt_d = skid_cnt_q;
    skid_wr_d  = skid_wr_q;
    skid_rd_d  = skid_rd_q;
    tag_wr_d   = tag_wr_q;
    tag_rd_d   = tag_rd_q;
    skid_mem_d = skid_mem_q;
    tag_mem_d  = tag_mem_q;
    err_d      = err_q | rsp_bad;

    if (flush) begin
      // No issue happens during flush, so out_cnt_d is exactly the number
      // of old-stream responses still to come back.
      pc_d       = redirect_pc;
      drop_cnt_d = out_cnt_d;
      state_d    = (out_cnt_d != '0) ? S_DRAIN : S_RUN;
      skid_cnt_d = '0;
      skid_wr_d  = '0;
      skid_rd_d  = '0;
      tag_wr_d   = '0;
      tag_rd_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_RUN;
        end
        S_RUN: begin
          if (issue) begin
            tag_mem_d[tag_wr_q] = pc_q;
            tag_wr_d            = ptr_inc(tag_wr_q);
            pc_d                = pc_q + 32'd4;
          end
          if (capture) begin
            skid_mem_d[skid_wr_q] = {tag_mem_q[tag_rd_q], imem_data};
            skid_wr_d             = ptr_inc(skid_wr_q);
            tag_rd_d              = ptr_inc(tag_rd_q);
          end
          if (pop) begin
            skid_rd_d = ptr_inc(skid_rd_q);
          end
          if (capture && !pop) begin
            skid_cnt_d = skid_cnt_q + CNT_ONE;
          end else if (!capture && pop) begin
            skid_cnt_d = skid_cnt_q - CNT_ONE;
          end
        end
        S_DRAIN: begin
          if (rsp_ok) begin
            drop_cnt_d = drop_cnt_q - CNT_ONE;
            if (drop_cnt_q == CNT_ONE) begin
              state_d = S_RUN;
            end
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      out_cnt_q  <= '0;
      drop_cnt_q <= '0;
      skid_cnt_q <= '0;
      skid_wr_q  <= '0;
      skid_rd_q  <= '0;
      tag_wr_q   <= '0;
      tag_rd_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      out_cnt_q  <= out_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      skid_cnt_q <= skid_cnt_d;
      skid_wr_q  <= skid_wr_d;
      skid_rd_q  <= skid_rd_d;
      tag_wr_q   <= tag_wr_d;
      tag_rd_q   <= tag_rd_d;
      err_q      <= err_d;
    end
  end

  // Storage only; validity is tracked by the reset pointers and counts.
  always_ff @(posedge clk) begin
    skid_mem_q <= skid_mem_d;
    tag_mem_q  <= tag_mem_d;
  end

`ifdef QUEUE
  always_ff @(posedge clk) begin
    $display("%s state=%0d pc=%h out_cnt=%0d skid_count=%0d drop_cnt=%0d",
             TAG, state_q, pc_q, out_cnt_q, skid_cnt_q, drop_cnt_q);
  end
`endif

endmodule

// File: tb/tb_fetch_enqueuer.sv
module tb_fetch_enqueuer;

  localparam logic [31:0] RESET_PC = 32'h0000_0100;
  localparam int          MAX_OUT  = 2;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        flush;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_data;
  logic        halt;
  logic        enque;
  logic [63:0] enque_data;
  logic        err;

  fetch_enqueuer #(.RESET_PC(RESET_PC), .MAX_OUT(MAX_OUT), .TAG("Fetch")) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_data(imem_data), .halt(halt),
    .enque(enque), .enque_data(enque_data), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // memory model: in-order responses with a due cycle
  typedef struct { logic [31:0] addr; int due; } mreq_t;
  mreq_t mem_q[$];
  int    cyc      = 0;
  int    last_due = 0;
  int    mem_lat  = 1;
  bit    mem_rand = 0;

  // reference model: the fetcher described with queues and counters
  typedef enum int { M_IDLE, M_RUN, M_DRAIN } mst_t;
  mst_t        m_st;
  logic [31:0] m_pc;
  logic [31:0] m_tags[$];
  logic [63:0] m_skid[$];
  int          m_out;
  int          m_drop;
  bit          m_err;

  logic        obs_req;
  logic [31:0] obs_addr;
  logic        obs_enq;
  logic [63:0] obs_data;
  logic        obs_err;

  typedef struct {
    bit          stall;
    bit          flush;
    bit          halt;
    logic [31:0] rp;
    bit          e_req;
    logic [31:0] e_addr;
    bit          e_enq;
    logic [31:0] e_pc;
  } vec_t;
  vec_t vt[11];

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_st   = M_IDLE;
    m_pc   = RESET_PC;
    m_out  = 0;
    m_drop = 0;
    m_err  = 0;
    m_tags.delete();
    m_skid.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; stall = 0; flush = 0; halt = 0; redirect_pc = '0;
    imem_valid = 0; imem_data = '0;
    mem_q.delete();
    last_due = 0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      imem_valid = 1'($urandom_range(0, 1));
      imem_data  = $urandom;
      #1;
      chk("rst_req", {63'd0, imem_req}, 64'd0);
      chk("rst_enq", {63'd0, enque}, 64'd0);
      chk("rst_data", enque_data, 64'd0);
      chk("rst_err", {63'd0, err}, 64'd0);
    end
  endtask

  // One clock: drive inputs at negedge, compare against the model, then
  // advance the model and the memory by what happens at the next posedge.
  task automatic step(input bit s, input bit f, input bit h, input logic [31:0] rp, input bit spur);
    bit          e_req, e_enq, ok;
    logic [63:0] e_data;
    int          due;
    @(negedge clk);
    cyc++;
    reset = 1'b1; stall = s; flush = f; halt = h; redirect_pc = rp;
    imem_valid = 1'b0;
    imem_data  = $urandom;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_valid = 1'b1;
      imem_data  = instr_of(mem_q[0].addr);
      void'(mem_q.pop_front());
    end else if (spur) begin
      imem_valid = 1'b1;
    end
    #1;
    e_req  = (m_st == M_RUN) && !s && !f && (m_out + m_skid.size() < MAX_OUT);
    e_enq  = (m_skid.size() > 0) && !h && !s && !f;
    e_data = e_enq ? m_skid[0] : 64'd0;
    obs_req = imem_req; obs_addr = imem_addr; obs_enq = enque;
    obs_data = enque_data; obs_err = err;
    chk("req", {63'd0, imem_req}, {63'd0, e_req});
    if (e_req) chk("addr", {32'd0, imem_addr}, {32'd0, m_pc});
    chk("enq", {63'd0, enque}, {63'd0, e_enq});
    chk("data", enque_data, e_data);
    chk("err", {63'd0, err}, {63'd0, m_err});
    if (imem_req) begin
      if (mem_rand) mem_lat = $urandom_range(1, 4);
      due = cyc + mem_lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      mem_q.push_back('{addr: imem_addr, due: due});
    end
    ok = imem_valid && (m_out > 0);
    if (imem_valid && m_out == 0) m_err = 1;
    if (f) begin
      if (ok) m_out--;
      m_tags.delete();
      m_skid.delete();
      m_pc   = rp;
      m_drop = m_out;
      m_st   = (m_drop > 0) ? M_DRAIN : M_RUN;
    end else begin
      case (m_st)
        M_IDLE: m_st = M_RUN;
        M_RUN: begin
          if (e_enq) void'(m_skid.pop_front());
          if (ok) begin
            m_skid.push_back({m_tags.pop_front(), imem_data});
            m_out--;
          end
          if (e_req) begin
            m_tags.push_back(m_pc);
            m_pc = m_pc + 32'd4;
            m_out++;
          end
        end
        default: begin
          if (ok) begin
            m_out--;
            m_drop--;
            if (m_drop == 0) m_st = M_RUN;
          end
        end
      endcase
    end
  endtask

  int n_iss;

  initial begin
    reset = 1'b0; stall = 0; flush = 0; halt = 0; redirect_pc = '0;
    imem_valid = 0; imem_data = '0;

    // steady fetch at latency 1, then a stall with a response arriving
    vt[0]  = '{0, 0, 0, 32'h0, 0, 32'h0,   0, 32'h0};
    vt[1]  = '{0, 0, 0, 32'h0, 1, 32'h100, 0, 32'h0};
    vt[2]  = '{0, 0, 0, 32'h0, 1, 32'h104, 0, 32'h0};
    vt[3]  = '{0, 0, 0, 32'h0, 0, 32'h0,   1, 32'h100};
    vt[4]  = '{0, 0, 0, 32'h0, 1, 32'h108, 1, 32'h104};
    vt[5]  = '{0, 0, 0, 32'h0, 1, 32'h10C, 0, 32'h0};
    vt[6]  = '{0, 0, 0, 32'h0, 0, 32'h0,   1, 32'h108};
    vt[7]  = '{0, 0, 0, 32'h0, 1, 32'h110, 1, 32'h10C};
    vt[8]  = '{1, 0, 0, 32'h0, 0, 32'h0,   0, 32'h0};
    vt[9]  = '{1, 0, 0, 32'h0, 0, 32'h0,   0, 32'h0};
    vt[10] = '{0, 0, 0, 32'h0, 1, 32'h114, 1, 32'h110};

    mem_rand = 0; mem_lat = 1;
    do_reset();
    for (int i = 0; i < 11; i++) begin
      step(vt[i].stall, vt[i].flush, vt[i].halt, vt[i].rp, 0);
      chk($sformatf("tbl%0d_req", i), {63'd0, obs_req}, {63'd0, vt[i].e_req});
      if (vt[i].e_req) chk($sformatf("tbl%0d_addr", i), {32'd0, obs_addr}, {32'd0, vt[i].e_addr});
      chk($sformatf("tbl%0d_enq", i), {63'd0, obs_enq}, {63'd0, vt[i].e_enq});
      chk($sformatf("tbl%0d_data", i), obs_data,
          vt[i].e_enq ? {vt[i].e_pc, instr_of(vt[i].e_pc)} : 64'd0);
    end

    // downstream halted: only MAX_OUT requests, then two back-to-back pushes
    do_reset();
    step(0, 0, 0, 0, 0);
    n_iss = 0;
    for (int i = 0; i < 11; i++) begin
      step(0, 0, 1, 0, 0);
      if (obs_req) n_iss++;
    end
    chk("halt_issues", 64'(n_iss), 64'd2);
    chk("halt_req_idle", {63'd0, obs_req}, 64'd0);
    step(0, 0, 0, 0, 0);
    chk("unhalt_enq0", {63'd0, obs_enq}, 64'd1);
    chk("unhalt_data0", obs_data, {32'h100, instr_of(32'h100)});
    step(0, 0, 0, 0, 0);
    chk("unhalt_enq1", {63'd0, obs_enq}, 64'd1);
    chk("unhalt_data1", obs_data, {32'h104, instr_of(32'h104)});
    chk("unhalt_req", {63'd0, obs_req}, 64'd1);
    chk("unhalt_addr", {32'd0, obs_addr}, 64'h108);

    // flush with two requests in flight at latency 3
    mem_lat = 3;
    do_reset();
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 1, 0, 32'h2000, 0);
    step(0, 0, 0, 0, 0);
    chk("drain1_req", {63'd0, obs_req}, 64'd0);
    chk("drain1_enq", {63'd0, obs_enq}, 64'd0);
    step(0, 0, 0, 0, 0);
    chk("drain2_req", {63'd0, obs_req}, 64'd0);
    chk("drain2_enq", {63'd0, obs_enq}, 64'd0);
    step(0, 0, 0, 0, 0);
    chk("redir_req", {63'd0, obs_req}, 64'd1);
    chk("redir_addr", {32'd0, obs_addr}, 64'h2000);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 0);

    // second flush while draining
    do_reset();
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 1, 0, 32'h2000, 0);
    step(0, 1, 0, 32'h3000, 0);
    chk("reflush_req", {63'd0, obs_req}, 64'd0);
    step(0, 0, 0, 0, 0);
    chk("redrain_req", {63'd0, obs_req}, 64'd0);
    chk("redrain_enq", {63'd0, obs_enq}, 64'd0);
    step(0, 0, 0, 0, 0);
    chk("reredir_req", {63'd0, obs_req}, 64'd1);
    chk("reredir_addr", {32'd0, obs_addr}, 64'h3000);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 0);

    // spurious response with nothing outstanding
    mem_lat = 1;
    do_reset();
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    chk("spur_err", {63'd0, obs_err}, 64'd1);
    chk("spur_enq", {63'd0, obs_enq}, 64'd0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0);
    chk("spur_err_sticky", {63'd0, obs_err}, 64'd1);

    // randomized traffic, with periodic mid-flight resets
    mem_rand = 1;
    for (int r = 0; r < 3; r++) begin
      do_reset();
      for (int i = 0; i < 1200; i++) begin
        logic [31:0] rp;
        rp = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
        step($urandom_range(0, 99) < 15, $urandom_range(0, 99) < 4,
             $urandom_range(0, 99) < 30, rp, 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
